fpu_mult_sequencer: RTL and testbench

Multi-cycle controller for the single-precision (IEEE-754 binary32) multiplier datapath. It performs these steps in order:
- accepts operand pairs over a valid/ready handshake;
- unpacks them and screens special cases;
- drives an iterative 24x24 shift-add mantissa multiply;
- adds exponents, normalizes, rounds, and returns the packed result with status flags.

It is the top-level sequencer sitting between the FPU issue logic and the normalization/rounding datapath.

---
 rtl/fpu_mult_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_fpu_mult_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_mult_sequencer.sv
// fpu_mult_sequencer
//   Multi-cycle binary32 multiplier controller. Accepts an operand pair over a
//   valid/ready handshake, screens special operands, runs a bit-serial 24x24
//   shift-add mantissa multiply, then normalizes, rounds (nearest-even) and
//   returns the packed product with overflow/underflow/invalid status.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  operand handshake; in_ready high only in IDLE
//   a, b                binary32 operands
//   out_valid,out_ready result handshake; result/flags held while stalled
//   result              packed binary32 product
//   overflow            result saturated to signed infinity
//   underflow           result flushed to signed zero
//   invalid             NaN operand or inf*0; result is canonical qNaN
//   busy                high in every state except IDLE
module fpu_mult_sequencer #(
  parameter int EXP_BIAS   = 127,
  parameter int MUL_CYCLES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid,
  output logic        busy
);

  localparam int CW = $clog2(MUL_CYCLES);

  typedef enum logic [2:0] {IDLE, CHECK, MUL, NORM, ROUND, DONE} state_t;

  state_t              state, state_nxt;
  logic [31:0]         op_a, op_a_nxt;
  logic [31:0]         op_b, op_b_nxt;
  logic                sign, sign_nxt;
  logic [23:0]         mcand, mcand_nxt;
  logic [23:0]         mplier, mplier_nxt;
  logic [47:0]         acc, acc_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic signed [9:0]   exp_sum, exp_sum_nxt;
  logic [23:0]         mant, mant_nxt;
  logic                guard, guard_nxt;
  logic                sticky, sticky_nxt;
  logic [31:0]         result_nxt;
  logic                overflow_nxt, underflow_nxt, invalid_nxt;

  // Operand unpack; exponent 0 is treated as zero (denormals flushed).
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign ea     = op_a[30:23];
  assign eb     = op_b[30:23];
  assign fa     = op_a[22:0];
  assign fb     = op_b[22:0];
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  // One shift-add step: conditional add into the upper half, carry kept as
  // the new MSB, whole accumulator shifted right by one.
  logic [24:0] step_sum;
  assign step_sum = {1'b0, acc[47:24]} + (mplier[0] ? {1'b0, mcand} : 25'd0);

  // Rounding: a carry out of the 24-bit mantissa means it was all ones, so
  // the rounded value is exactly 1.0 at the next exponent.
  logic              round_up;
  logic [24:0]       mant_rnd;
  logic signed [9:0] exp_rnd;
  logic [23:0]       mant_fin;

  assign round_up = guard & (sticky | mant[0]);
  assign mant_rnd = {1'b0, mant} + {24'd0, round_up};
  assign exp_rnd  = mant_rnd[24] ? exp_sum + 10'sd1 : exp_sum;
  assign mant_fin = mant_rnd[24] ? 24'h800000 : mant_rnd[23:0];

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt     = state;
    op_a_nxt      = op_a;
    op_b_nxt      = op_b;
    sign_nxt      = sign;
    mcand_nxt     = mcand;
    mplier_nxt    = mplier;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    exp_sum_nxt   = exp_sum;
    mant_nxt      = mant;
    guard_nxt     = guard;
    sticky_nxt    = sticky;
    result_nxt    = result;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    invalid_nxt   = invalid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          op_a_nxt  = a;
          op_b_nxt  = b;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        sign_nxt      = op_a[31] ^ op_b[31];
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        invalid_nxt   = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          result_nxt  = 32'h7FC00000;
          invalid_nxt = 1'b1;
          state_nxt   = DONE;
        end else if (a_inf || b_inf) begin
          result_nxt = {op_a[31] ^ op_b[31], 31'h7F800000};
          state_nxt  = DONE;
        end else if (a_zero || b_zero) begin
          result_nxt = {op_a[31] ^ op_b[31], 31'd0};
          state_nxt  = DONE;
        end else begin
          mcand_nxt   = {1'b1, fa};
          mplier_nxt  = {1'b1, fb};
          // Modulo-1024 sum reads correctly as 10-bit signed: range is
          // -125..381, so no wrap.
          exp_sum_nxt = $signed(10'(ea) + 10'(eb) - 10'(EXP_BIAS));
          acc_nxt     = 48'd0;
          cnt_nxt     = '0;
          state_nxt   = MUL;
        end
      end
      MUL: begin
        acc_nxt    = {step_sum, acc[23:1]};
        mplier_nxt = {1'b0, mplier[23:1]};
        cnt_nxt    = cnt + CW'(1);
        if (cnt == CW'(MUL_CYCLES - 1)) state_nxt = NORM;
      end
      NORM: begin
        if (acc[47]) begin
          mant_nxt    = acc[47:24];
          guard_nxt   = acc[23];
          sticky_nxt  = |acc[22:0];
          exp_sum_nxt = exp_sum + 10'sd1;
        end else begin
          mant_nxt   = acc[46:23];
          guard_nxt  = acc[22];
          sticky_nxt = |acc[21:0];
        end
        state_nxt = ROUND;
      end
      ROUND: begin
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        invalid_nxt   = 1'b0;
        if (exp_rnd >= 10'sd255) begin
          result_nxt   = {sign, 31'h7F800000};
          overflow_nxt = 1'b1;
        end else if (exp_rnd <= 10'sd0) begin
          result_nxt    = {sign, 31'd0};
          underflow_nxt = 1'b1;
        end else begin
          result_nxt = {sign, exp_rnd[7:0], mant_fin[22:0]};
        end
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          overflow_nxt  = 1'b0;
          underflow_nxt = 1'b0;
          invalid_nxt   = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      sign      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      exp_sum   <= '0;
      mant      <= '0;
      guard     <= 1'b0;
      sticky    <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_a      <= op_a_nxt;
      op_b      <= op_b_nxt;
      sign      <= sign_nxt;
      mcand     <= mcand_nxt;
      mplier    <= mplier_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      exp_sum   <= exp_sum_nxt;
      mant      <= mant_nxt;
      guard     <= guard_nxt;
      sticky    <= sticky_nxt;
      result    <= result_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
      invalid   <= invalid_nxt;
    end
  end

endmodule

// File: tb/tb_fpu_mult_sequencer.sv
module tb_fpu_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow, underflow, invalid, busy;

  int vectors = 0;
  int miscompares = 0;

  fpu_mult_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow),
    .invalid(invalid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Drive one operand pair and wait for out_valid. lat counts the cycle
  // after the accept edge as 1; a value of 200 means it never arrived.
  task automatic run_op(input logic [31:0] opa, input logic [31:0] opb,
                        output logic [31:0] res, output logic [2:0] flg,
                        output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    a = opa; b = opb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    res = result;
    flg = {overflow, underflow, invalid};
  endtask

  // Directed operand table: {a, b, expected result, expected {ovf,unf,inv}, latency}
  task automatic test_vectors();
    logic [31:0] ta [8], tb_ [8], tr [8];
    logic [2:0]  tf [8];
    int          tl [8];
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    ta[0]=32'h3FC00000; tb_[0]=32'h40000000; tr[0]=32'h40400000; tf[0]=3'b000; tl[0]=28;
    ta[1]=32'h7F000000; tb_[1]=32'h40000000; tr[1]=32'h7F800000; tf[1]=3'b100; tl[1]=28;
    ta[2]=32'hFF000000; tb_[2]=32'h40000000; tr[2]=32'hFF800000; tf[2]=3'b100; tl[2]=28;
    ta[3]=32'h00800000; tb_[3]=32'h00800000; tr[3]=32'h00000000; tf[3]=3'b010; tl[3]=28;
    ta[4]=32'h7F800000; tb_[4]=32'h00000000; tr[4]=32'h7FC00000; tf[4]=3'b001; tl[4]=2;
    ta[5]=32'h7FC00001; tb_[5]=32'h3F800000; tr[5]=32'h7FC00000; tf[5]=3'b001; tl[5]=2;
    ta[6]=32'h3F800001; tb_[6]=32'h3F800001; tr[6]=32'h3F800002; tf[6]=3'b000; tl[6]=28;
    ta[7]=32'h3FFFFFFF; tb_[7]=32'h3FFFFFFF; tr[7]=32'h407FFFFE; tf[7]=3'b000; tl[7]=28;
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb_[i], res, flg, lat);
      vectors++;
      if (res !== tr[i]) begin
        miscompares++;
        $display("FAIL vec%0d result: got %h expected %h", i, res, tr[i]);
      end
      vectors++;
      if (flg !== tf[i]) begin
        miscompares++;
        $display("FAIL vec%0d flags: got %b expected %b", i, flg, tf[i]);
      end
      vectors++;
      if (lat !== tl[i]) begin
        miscompares++;
        $display("FAIL vec%0d latency: got %0d expected %0d", i, lat, tl[i]);
      end
    end
    // Transfer on the next edge returns to IDLE.
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_transfer: got ov=%b ir=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_hs: got ir/ov/busy=%b expected 100", {in_ready, out_valid, busy});
    end
    vectors++;
    if ({result, overflow, underflow, invalid} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_out: got result=%h flags=%b expected 0", result, {overflow, underflow, invalid});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    out_ready = 1'b0;
    run_op(32'h3FC00000, 32'h40000000, res, flg, lat);
    vectors++;
    if (lat !== 28) begin
      miscompares++;
      $display("FAIL bp_latency: got %0d expected 28", lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'h7F800000; b = 32'h00000000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++;
      if (result !== 32'h40400000 || {overflow, underflow, invalid} !== 3'b000 ||
          out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got result=%h flags=%b ov=%b ir=%b expected 40400000 000 1 0",
                 i, result, {overflow, underflow, invalid}, out_valid, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got ov=%b ir=%b expected 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_extra: got busy=%b ov=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    @(negedge clk);
    a = 32'h3FFFFFFF; b = 32'h7F000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_busy: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_abort: got ov=%b ir=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h40000000, 32'h40000000, res, flg, lat);
    vectors++;
    if (res !== 32'h40800000 || flg !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_next_op: got result=%h flags=%b expected 40800000 000", res, flg);
    end
    vectors++;
    if (lat !== 28) begin
      miscompares++;
      $display("FAIL rst_next_latency: got %0d expected 28", lat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
